// File: rtl/cascade_ack_responder.sv
// INTA sequencer for an 8259-style interrupt controller: tracks the INTA pulse
// train, resolves cascade addressing and drives the acknowledge bytes.
module cascade_ack_responder (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_acknowledge_n,
  input  logic [2:0] cascade_in,
  input  logic [2:0] cascade_id,
  input  logic       single_or_cascade_config,
  input  logic       slave_mode,
  input  logic       slave_irq_at_master,
  input  logic       u8086_mode,
  input  logic [7:0] interrupt_vector,
  input  logic [7:0] call_address_low,
  input  logic [7:0] call_address_high,
  output logic [7:0] data_bus_out,
  output logic       data_bus_out_enable,
  output logic       latch_in_service,
  output logic       end_of_acknowledge,
  output logic       acknowledge_abort,
  output logic       slave_selected
);

  localparam int unsigned GAP_W = 8;
  localparam logic [GAP_W-1:0] GAP_LIMIT   = GAP_W'(255);
  localparam logic [7:0]       CALL_OPCODE = 8'hCD;

  typedef enum logic [2:0] {IDLE, P1, G1, P2, G2, P3} state_t;

  state_t           state;
  logic             inta_q;
  logic             mode_q;
  logic [GAP_W-1:0] gap_counter;

  logic fall;
  logic rise;
  logic respond;

  assign fall    = inta_q & ~interrupt_acknowledge_n;
  assign rise    = ~inta_q & interrupt_acknowledge_n;
  // Whether this device owns the data bus for the vector/address bytes.
  assign respond = single_or_cascade_config | (slave_mode & slave_selected) |
                   (~slave_mode & ~slave_irq_at_master);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      inta_q              <= 1'b1;
      mode_q              <= 1'b0;
      gap_counter         <= '0;
      slave_selected      <= 1'b0;
      data_bus_out        <= 8'h00;
      data_bus_out_enable <= 1'b0;
      latch_in_service    <= 1'b0;
      end_of_acknowledge  <= 1'b0;
      acknowledge_abort   <= 1'b0;
    end else begin
      inta_q             <= interrupt_acknowledge_n;
      latch_in_service   <= 1'b0;
      end_of_acknowledge <= 1'b0;
      acknowledge_abort  <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            state            <= P1;
            mode_q           <= u8086_mode;
            slave_selected   <= 1'b0;
            latch_in_service <= 1'b1;
            // 8080 masters and single-mode parts supply the CALL opcode.
            if (!u8086_mode && (!slave_mode || single_or_cascade_config)) begin
              data_bus_out        <= CALL_OPCODE;
              data_bus_out_enable <= 1'b1;
            end
          end
        end
        P1: begin
          if (rise) begin
            state               <= G1;
            gap_counter         <= '0;
            slave_selected      <= slave_mode & ~single_or_cascade_config &
                                   (cascade_in == cascade_id);
            data_bus_out        <= 8'h00;
            data_bus_out_enable <= 1'b0;
          end
        end
        G1: begin
          if (fall) begin
            state <= P2;
            if (respond) begin
              data_bus_out        <= mode_q ? interrupt_vector : call_address_low;
              data_bus_out_enable <= 1'b1;
            end
          end else if (gap_counter == GAP_LIMIT) begin
            state             <= IDLE;
            acknowledge_abort <= 1'b1;
          end else begin
            gap_counter <= gap_counter + GAP_W'(1);
          end
        end
        P2: begin
          if (rise) begin
            data_bus_out        <= 8'h00;
            data_bus_out_enable <= 1'b0;
            if (mode_q) begin
              state              <= IDLE;
              end_of_acknowledge <= 1'b1;
            end else begin
              state       <= G2;
              gap_counter <= '0;
            end
          end
        end
        G2: begin
          if (fall) begin
            state <= P3;
            if (respond) begin
              data_bus_out        <= call_address_high;
              data_bus_out_enable <= 1'b1;
            end
          end else if (gap_counter == GAP_LIMIT) begin
            state             <= IDLE;
            acknowledge_abort <= 1'b1;
          end else begin
            gap_counter <= gap_counter + GAP_W'(1);
          end
        end
        P3: begin
          if (rise) begin
            state               <= IDLE;
            end_of_acknowledge  <= 1'b1;
            data_bus_out        <= 8'h00;
            data_bus_out_enable <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cascade_ack_responder.sv
// Directed bench for cascade_ack_responder: walks INTA sequences in each mode
// and compares outputs against hand-computed values.
module tb_cascade_ack_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       inta_n;
  logic [2:0] cascade_in;
  logic [2:0] cascade_id;
  logic       single_cfg;
  logic       slave_mode;
  logic       slave_irq;
  logic       u8086;
  logic [7:0] vector;
  logic [7:0] addr_lo;
  logic [7:0] addr_hi;
  logic [7:0] data;
  logic       en;
  logic       lis;
  logic       eoa;
  logic       abort;
  logic       sel;

  int checks = 0;
  int errors = 0;

  cascade_ack_responder dut (
    .clock                    (clock),
    .reset                    (reset),
    .interrupt_acknowledge_n  (inta_n),
    .cascade_in               (cascade_in),
    .cascade_id               (cascade_id),
    .single_or_cascade_config (single_cfg),
    .slave_mode               (slave_mode),
    .slave_irq_at_master      (slave_irq),
    .u8086_mode               (u8086),
    .interrupt_vector         (vector),
    .call_address_low         (addr_lo),
    .call_address_high        (addr_hi),
    .data_bus_out             (data),
    .data_bus_out_enable      (en),
    .latch_in_service         (lis),
    .end_of_acknowledge       (eoa),
    .acknowledge_abort        (abort),
    .slave_selected           (sel)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go_low();
    inta_n = 1'b0;
    tick();
  endtask

  task automatic go_high();
    inta_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; inta_n = 1'b1; cascade_in = 3'd0; cascade_id = 3'd0;
    single_cfg = 1'b1; slave_mode = 1'b0; slave_irq = 1'b0; u8086 = 1'b1;
    vector = 8'h00; addr_lo = 8'h00; addr_hi = 8'h00;
    tick(); tick();
    checks++; if ({data, en, lis, eoa, abort, sel} !== 13'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", {data, en, lis, eoa, abort, sel}); end
    reset = 1'b0;
    tick();
    checks++; if ({data, en, lis, eoa, abort} !== 12'd0) begin errors++; $display("FAIL reset_idle got %h want 0", {data, en, lis, eoa, abort}); end
  endtask

  task automatic test_8086_single();
    single_cfg = 1'b1; slave_mode = 1'b0; u8086 = 1'b1; vector = 8'h48;
    go_low();
    checks++; if (lis !== 1'b1) begin errors++; $display("FAIL s86_lis got %b want 1", lis); end
    checks++; if ({en, data} !== 9'h000) begin errors++; $display("FAIL s86_p1_nodrive got %h want 000", {en, data}); end
    tick();
    checks++; if (lis !== 1'b0) begin errors++; $display("FAIL s86_lis_width got %b want 0", lis); end
    go_high();
    checks++; if (eoa !== 1'b0) begin errors++; $display("FAIL s86_p1_eoa got %b want 0", eoa); end
    tick();
    go_low();
    checks++; if ({en, data} !== 9'h148) begin errors++; $display("FAIL s86_p2_vec got %h want 148", {en, data}); end
    checks++; if (lis !== 1'b0) begin errors++; $display("FAIL s86_p2_lis got %b want 0", lis); end
    go_high();
    checks++; if ({en, data, eoa} !== 10'b0_00000000_1) begin errors++; $display("FAIL s86_end got %b want 0000000001", {en, data, eoa}); end
    tick();
    checks++; if (eoa !== 1'b0) begin errors++; $display("FAIL s86_eoa_width got %b want 0", eoa); end
  endtask

  task automatic test_8080_master();
    single_cfg = 1'b0; slave_mode = 1'b0; slave_irq = 1'b0; u8086 = 1'b0;
    addr_lo = 8'h20; addr_hi = 8'h30;
    go_low();
    checks++; if ({lis, en, data} !== 10'b1_1_11001101) begin errors++; $display("FAIL m80_p1 got %b want 1111001101", {lis, en, data}); end
    go_high();
    checks++; if ({en, data} !== 9'h000) begin errors++; $display("FAIL m80_p1_release got %h want 000", {en, data}); end
    tick(); tick();
    go_low();
    checks++; if ({en, data} !== 9'h120) begin errors++; $display("FAIL m80_p2 got %h want 120", {en, data}); end
    go_high();
    checks++; if ({en, eoa} !== 2'b00) begin errors++; $display("FAIL m80_p2_end got %b want 00", {en, eoa}); end
    tick();
    go_low();
    checks++; if ({en, data} !== 9'h130) begin errors++; $display("FAIL m80_p3 got %h want 130", {en, data}); end
    go_high();
    checks++; if ({en, data, eoa} !== 10'b0_00000000_1) begin errors++; $display("FAIL m80_end got %b want 0000000001", {en, data, eoa}); end
    tick();
  endtask

  task automatic test_8086_slave();
    single_cfg = 1'b0; slave_mode = 1'b1; u8086 = 1'b1; vector = 8'h71;
    cascade_id = 3'd5; cascade_in = 3'd5;
    go_low();
    checks++; if ({en, data} !== 9'h000) begin errors++; $display("FAIL sl_p1_nodrive got %h want 000", {en, data}); end
    go_high();
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL sl_match got %b want 1", sel); end
    cascade_in = 3'd2; slave_mode = 1'b0; single_cfg = 1'b1;
    tick();
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL sl_hold got %b want 1", sel); end
    slave_mode = 1'b1; single_cfg = 1'b0;
    go_low();
    checks++; if ({en, data} !== 9'h171) begin errors++; $display("FAIL sl_vec got %h want 171", {en, data}); end
    go_high();
    checks++; if (eoa !== 1'b1) begin errors++; $display("FAIL sl_end got %b want 1", eoa); end
    tick();
    cascade_in = 3'd3;
    go_low(); go_high();
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL sl_nomatch got %b want 0", sel); end
    tick();
    go_low();
    checks++; if ({en, data} !== 9'h000) begin errors++; $display("FAIL sl_quiet got %h want 000", {en, data}); end
    go_high();
    checks++; if ({en, eoa} !== 2'b01) begin errors++; $display("FAIL sl_quiet_end got %b want 01", {en, eoa}); end
    tick();
  endtask

  task automatic test_8080_cascaded_irq();
    single_cfg = 1'b0; slave_mode = 1'b0; slave_irq = 1'b1; u8086 = 1'b0;
    addr_lo = 8'h44; addr_hi = 8'h55;
    go_low();
    checks++; if ({en, data} !== 9'h1CD) begin errors++; $display("FAIL ci_p1 got %h want 1cd", {en, data}); end
    go_high(); tick();
    go_low();
    checks++; if ({en, data} !== 9'h000) begin errors++; $display("FAIL ci_p2 got %h want 000", {en, data}); end
    go_high(); tick();
    go_low();
    checks++; if ({en, data} !== 9'h000) begin errors++; $display("FAIL ci_p3 got %h want 000", {en, data}); end
    go_high();
    checks++; if (eoa !== 1'b1) begin errors++; $display("FAIL ci_end got %b want 1", eoa); end
    tick();
    slave_irq = 1'b0;
  endtask

  task automatic test_gap_timeout();
    single_cfg = 1'b1; slave_mode = 1'b0; u8086 = 1'b1; vector = 8'h9A;
    go_low(); go_high();
    for (int i = 0; i < 255; i++) tick();
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", abort); end
    tick();
    checks++; if ({abort, en, eoa} !== 3'b100) begin errors++; $display("FAIL to_abort got %b want 100", {abort, en, eoa}); end
    tick();
    checks++; if (abort !== 1'b0) begin errors++; $display("FAIL to_abort_width got %b want 0", abort); end
    go_low();
    checks++; if ({lis, en} !== 2'b10) begin errors++; $display("FAIL to_restart got %b want 10", {lis, en}); end
    go_high();
    for (int i = 0; i < 255; i++) tick();
    go_low();
    checks++; if ({abort, en, data} !== 10'b0_1_10011010) begin errors++; $display("FAIL to_fall_wins got %b want 0110011010", {abort, en, data}); end
    go_high();
    checks++; if ({eoa, abort} !== 2'b10) begin errors++; $display("FAIL to_fall_end got %b want 10", {eoa, abort}); end
    tick();
  endtask

  task automatic test_reset_mid();
    single_cfg = 1'b1; slave_mode = 1'b0; u8086 = 1'b1; vector = 8'h3C;
    go_low(); go_high(); tick();
    go_low();
    checks++; if ({en, data} !== 9'h13C) begin errors++; $display("FAIL rm_p2 got %h want 13c", {en, data}); end
    reset = 1'b1;
    #1;
    checks++; if ({en, data} !== 9'h000) begin errors++; $display("FAIL rm_async got %h want 000", {en, data}); end
    inta_n = 1'b1;
    tick(); tick();
    checks++; if ({eoa, abort, lis} !== 3'b000) begin errors++; $display("FAIL rm_nopulse got %b want 000", {eoa, abort, lis}); end
    reset = 1'b0;
    tick();
    checks++; if ({eoa, abort, lis} !== 3'b000) begin errors++; $display("FAIL rm_release got %b want 000", {eoa, abort, lis}); end
    vector = 8'hE1;
    go_low();
    checks++; if (lis !== 1'b1) begin errors++; $display("FAIL rm_new_p1 got %b want 1", lis); end
    go_high(); tick();
    go_low();
    checks++; if ({en, data} !== 9'h1E1) begin errors++; $display("FAIL rm_new_p2 got %h want 1e1", {en, data}); end
    go_high();
    checks++; if (eoa !== 1'b1) begin errors++; $display("FAIL rm_new_end got %b want 1", eoa); end
    tick();
  endtask

  initial begin
    test_reset();
    test_8086_single();
    test_8080_master();
    test_8086_slave();
    test_8080_cascaded_irq();
    test_gap_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cascade_ack_responder.md
CASCADE_ACK_RESPONDER -- requirements
Module: cascade_ack_responder

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- interrupt_acknowledge_n  in  1  INTA, active-low, synchronous to clock
- cascade_in  in  3  CAS lines as driven by the master
- cascade_id  in  3  own slave ID (ICW3)
- single_or_cascade_config  in  1  1 = single mode
- slave_mode  in  1  1 = this device is a cascade slave
- slave_irq_at_master  in  1  master only: acked IRQ is a cascade input
- u8086_mode  in  1  1 = 8086 two-pulse, 0 = 8080 three-pulse
- interrupt_vector  in  8  8086 vector byte
- call_address_low  in  8  8080 second byte
- call_address_high  in  8  8080 third byte
- data_bus_out  out  8  byte driven during INTA
- data_bus_out_enable  out  1  data bus driver enable
- latch_in_service  out  1  one-cycle pulse: set ISR
- end_of_acknowledge  out  1  one-cycle pulse: sequence complete
- acknowledge_abort  out  1  one-cycle pulse: sequence timed out
- slave_selected  out  1  latched CAS match result

Function
REQ-002 SHALL register interrupt_acknowledge_n into inta_q; fall = inta_q & ~INTA_n; rise = ~inta_q & INTA_n.
REQ-003 SHALL implement states IDLE, P1, G1, P2, G2, P3 (P = INTA low, G = gap between pulses).
REQ-004 IDLE->P1 on fall, latching u8086_mode into mode_q and pulsing latch_in_service; other events in IDLE ignored.
REQ-005 P1->G1, P2->G2 (8080), P3->IDLE on rise; G1->P2, G2->P3 on fall.
REQ-006 In 8086 mode_q, P2->IDLE on rise; G2/P3 unreachable.
REQ-007 On P1 rise SHALL set slave_selected = slave_mode & ~single_or_cascade_config & (cascade_in == cascade_id); held until next IDLE->P1.
REQ-008 respond = single_or_cascade_config | (slave_mode & slave_selected) | (~slave_mode & ~slave_irq_at_master).
REQ-009 Drive bytes (registered, valid the cycle after the edge is detected, dropped at the edge detecting rise):
- P1, 8080, ~slave_mode or single: 0xCD
- P1, 8086: none
- P2 with respond: interrupt_vector (8086) / call_address_low (8080)
- P3 with respond: call_address_high
REQ-010 data_bus_out SHALL be 0x00 whenever data_bus_out_enable = 0.
REQ-011 end_of_acknowledge SHALL pulse on the rise ending the last pulse (P2 for 8086, P3 for 8080), regardless of respond.
REQ-012 8-bit gap_counter SHALL clear on entry to G1/G2 and increment per cycle in G; reaching 255 -> IDLE, acknowledge_abort pulse, no end_of_acknowledge.
REQ-013 fall and counter = 255 in same cycle: fall wins (advance to P), no abort.
REQ-014 Mode/config input changes mid-sequence SHALL not alter mode_q or slave_selected until next IDLE->P1.
REQ-015 Pulses SHALL last exactly one clock; never two pulses in one cycle.

Reset
REQ-016 reset SHALL force: state IDLE, inta_q = 1, gap_counter = 0, mode_q = 0, slave_selected = 0, data_bus_out = 0x00, all 1-bit outputs 0.
REQ-017 reset mid-sequence SHALL abandon it with no end_of_acknowledge/acknowledge_abort pulse; first fall after release starts a new P1.

Verification
REQ-018 8086 single mode, vector 0x48, two INTA pulses -> latch_in_service at pulse 1, no drive in P1, 0x48 enabled in P2, end_of_acknowledge at P2 rise.
REQ-019 8080 master, slave_irq_at_master = 0, addresses 0x20/0x30 -> bytes 0xCD, 0x20, 0x30 on pulses 1-3; end at pulse 3 rise.
REQ-020 8086 slave, cascade_id = 5, cascade_in = 5 then 3 across two sequences -> slave_selected 1 and drives vector; then 0 with enable held low, end_of_acknowledge still pulses.
REQ-021 8080 master, slave_irq_at_master = 1 -> 0xCD in P1, no drive in P2/P3.
REQ-022 INTA held high 255 cycles in G1 -> acknowledge_abort pulse, state IDLE, enable 0; fall on counter-255 cycle -> P2, no abort.
REQ-023 reset asserted during P2 with enable high -> enable 0 and data 0x00 immediately, no completion pulse; next INTA sequence completes normally.
